// File: rtl/mul_mdc_ctrl_master.sv
// Command-driven peripheral bus master with sticky HWPE event waits.
// Optional MUL_MDC_CTRL_TIMEOUT_EN adds a per-state watchdog that aborts to an error response.
module mul_mdc_ctrl_master #(
  parameter int unsigned ID             = 10,
  parameter int unsigned N_EVT          = 4,
  parameter int unsigned MASTER_ID      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [31:0]      cmd_add_i,
  input  logic [31:0]      cmd_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_err_o,
  output logic             periph_req_o,
  input  logic             periph_gnt_i,
  output logic [31:0]      periph_add_o,
  output logic             periph_wen_o,
  output logic [3:0]       periph_be_o,
  output logic [31:0]      periph_data_o,
  output logic [ID-1:0]    periph_id_o,
  input  logic [31:0]      periph_r_data_i,
  input  logic             periph_r_valid_i,
  input  logic [ID-1:0]    periph_r_id_i,
  input  logic [N_EVT-1:0] evt_i,
  output logic             busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_WAIT_EVT, S_RSP_OUT} state_e;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_WAIT_EVT, OP_NOP} op_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [31:0]       add_q, add_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [N_EVT-1:0]  sticky_q, sticky_d;
  logic [N_EVT-1:0]  sticky_clr;
  logic [N_EVT-1:0]  evt_sel;
  logic              evt_hit;
  logic              idx_bad;
  logic              id_err;
  logic              timeout;

  // Event index lives in the low nibble of the latched command data.
  always_comb begin
    for (int k = 0; k < N_EVT; k++) begin
      evt_sel[k] = (data_q[3:0] == 4'(k));
    end
  end

  assign evt_hit = |(sticky_q & evt_sel);
  assign idx_bad = (32'(data_q[3:0]) >= N_EVT);
  assign id_err  = (periph_r_id_i != ID'(MASTER_ID));

`ifdef MUL_MDC_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Restarts on every state change, so each waiting state gets a full budget.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) &&
        (state_q == S_REQ || state_q == S_RESP || state_q == S_WAIT_EVT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    add_d      = add_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    sticky_clr = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = op_e'(cmd_op_i);
          add_d  = cmd_add_i;
          data_d = cmd_data_i;
          case (op_e'(cmd_op_i))
            OP_WRITE, OP_READ: state_d = S_REQ;
            OP_WAIT_EVT:       state_d = S_WAIT_EVT;
            default:           state_d = S_IDLE;
          endcase
        end
      end
      S_REQ: begin
        if (periph_gnt_i) begin
          state_d = S_RESP;
        end else if (timeout) begin
          state_d    = S_RSP_OUT;
          rsp_err_d  = 1'b1;
          rsp_data_d = TIMEOUT_DATA;
        end
      end
      S_RESP: begin
        if (periph_r_valid_i) begin
          rsp_err_d = id_err;
          if (op_q == OP_READ) begin
            state_d    = S_RSP_OUT;
            rsp_data_d = periph_r_data_i;
          end else if (id_err) begin
            // A write only reports back when the completion came from the wrong id.
            state_d    = S_RSP_OUT;
            rsp_data_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          state_d    = S_RSP_OUT;
          rsp_err_d  = 1'b1;
          rsp_data_d = TIMEOUT_DATA;
        end
      end
      S_WAIT_EVT: begin
        if (idx_bad) begin
          state_d    = S_RSP_OUT;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (evt_hit) begin
          state_d    = S_IDLE;
          sticky_clr = evt_sel;
        end else if (timeout) begin
          state_d    = S_RSP_OUT;
          rsp_err_d  = 1'b1;
          rsp_data_d = TIMEOUT_DATA;
        end
      end
      S_RSP_OUT: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new pulse on the consuming cycle survives the clear.
    sticky_d = (sticky_q & ~sticky_clr) | evt_i;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      op_q       <= OP_WRITE;
      add_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      sticky_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      add_q      <= add_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign rsp_valid_o   = (state_q == S_RSP_OUT);
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign periph_req_o  = (state_q == S_REQ);
  assign periph_add_o  = add_q;
  assign periph_data_o = data_q;
  assign periph_wen_o  = (op_q == OP_READ);
  assign periph_be_o   = (state_q == S_REQ) ? 4'hF : 4'h0;
  assign periph_id_o   = ID'(MASTER_ID);

endmodule
